mem_port_ctrl: RTL and testbench

Single-port bus master that sits directly upstream of the shared tristate memory. It turns a valid/ready request stream (read or write, address, write data) into the memory's `wr`/`rd`/`addr`/`data` bus protocol. It guarantees the bidirectional data bus is never driven by both sides. Read data returns on a separate valid/ready response channel.

---
 rtl/mem_ctrl_pkg.sv | 8 +
 rtl/mem_init_seq.sv | 15 +
 rtl/mem_port_ctrl.sv | 70 +++++++
 tb/tb_mem_port_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared FSM state, op encoding and default geometry for the memory port
package mem_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, INIT} state_t;
  localparam logic OP_READ = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  localparam int MEM_AWIDTH = 5;
  localparam int MEM_DWIDTH = 8;
endpackage

// File: rtl/mem_init_seq.sv
// mem_init_seq: address sweep counter for clearing memory; ports clk, rst_n, start (count enable), addr (current sweep address), done (last address this cycle)
module mem_init_seq #(
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [AWIDTH-1:0] addr,
  output logic              done
);
  always_ff @(posedge clk)
    if (!rst_n) addr <= '0;
    else if (start) addr <= addr + 1'b1;
  assign done = start && &addr;
endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: valid/ready request stream to tristate memory bus master; ports clk, rst_n (sync active-low), req_* request channel, rsp_* read response channel, mem_* memory bus (mem_data bidirectional), init_done; optional memory clear sweep under MEM_PORT_CTRL_INIT_EN
module mem_port_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AWIDTH = MEM_AWIDTH,
  parameter int DWIDTH = MEM_DWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [AWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0] mem_data,
  output logic              init_done
);
  state_t state, state_n;
  logic [AWIDTH-1:0] addr_q, init_addr;
  logic [DWIDTH-1:0] wdata_q, rsp_q;
  logic init_last;
`ifdef MEM_PORT_CTRL_INIT_EN
  localparam state_t RST_STATE = INIT;
  mem_init_seq #(.AWIDTH(AWIDTH)) u_init (
    .clk(clk), .rst_n(rst_n), .start(state == INIT), .addr(init_addr), .done(init_last)
  );
  assign init_done = state != INIT;
`else
  localparam state_t RST_STATE = IDLE;
  assign init_addr = '0;
  assign init_last = 1'b0;
  assign init_done = 1'b1;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= RST_STATE;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_q <= '0;
    end else begin
      state <= state_n;
      if (req_valid && req_ready) begin
        addr_q <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == READ) rsp_q <= mem_data;
    end
  always_comb begin
    state_n = state;
    if (state == IDLE && req_valid) state_n = (req_we == OP_WRITE) ? WRITE : READ;
    if (state == WRITE) state_n = IDLE;
    if (state == READ) state_n = RESP;
    if (state == RESP && rsp_ready) state_n = IDLE;
    if (state == INIT && init_last) state_n = IDLE;
  end
  // gating with rst_n releases the bus and blocks handshakes while reset is held
  assign req_ready = rst_n && state == IDLE;
  assign rsp_valid = rst_n && state == RESP;
  assign rsp_data = rsp_q;
  assign mem_wr = rst_n && (state == WRITE || state == INIT);
  assign mem_rd = rst_n && state == READ;
  assign mem_addr = (state == INIT) ? init_addr : addr_q;
  assign mem_data = mem_wr ? ((state == INIT) ? '0 : wdata_q) : 'z;
endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: randomized self-checking bench with a tristate memory model and array scoreboard
module tb_mem_port_ctrl;
  logic clk = 0, rst_n = 0, req_valid = 0, req_we = 0, rsp_ready = 1;
  logic [4:0] req_addr = 0;
  logic [7:0] req_wdata = 0;
  logic req_ready, rsp_valid, mem_wr, mem_rd, init_done;
  logic [7:0] rsp_data;
  logic [4:0] mem_addr;
  wire [7:0] mem_data;
  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];
  int checks = 0, errors = 0;
  bit mon_en = 0;

  mem_port_ctrl #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .init_done(init_done)
  );

  always #5 clk = ~clk;

  assign mem_data = mem_rd ? mem[mem_addr] : 8'bz;
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_data;

  always @(negedge clk) if (mon_en) begin
    checks++;
    if (mem_wr && mem_rd) begin errors++; $display("FAIL bus_excl: mem_wr=%b mem_rd=%b both high", mem_wr, mem_rd); end
    if (mem_rd) begin
      checks++;
      if (mem_data !== mem[mem_addr]) begin
        errors++; $display("FAIL bus_read: mem_data=%h expected memory word %h", mem_data, mem[mem_addr]);
      end
    end
  end

  task automatic send(input logic we, input logic [4:0] a, input logic [7:0] d);
    int n = 0;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    while (!req_ready && n < 64) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready) begin errors++; $display("FAIL accept: req_ready=%b after %0d cycles, required 1", req_ready, n); end
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
  endtask

  task automatic recv(input logic [7:0] exp, input int stall);
    int n = 0;
    rsp_ready = 0;
    repeat (stall) @(negedge clk);
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (!rsp_valid || rsp_data !== exp) begin
      errors++; $display("FAIL read_data: rsp_valid=%b rsp_data=%h, required 1/%h", rsp_valid, rsp_data, exp);
    end
    rsp_ready = 1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, mem_wr, mem_rd} !== 4'b0 || mem_addr !== 5'd0 || rsp_data !== 8'd0) begin
      errors++; $display("FAIL reset_vals: rdy=%b vld=%b wr=%b rd=%b addr=%h data=%h, required all 0",
                          req_ready, rsp_valid, mem_wr, mem_rd, mem_addr, rsp_data);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
`ifdef MEM_PORT_CTRL_INIT_EN
    if (req_ready !== 1'b0 || init_done !== 1'b0) begin
      errors++; $display("FAIL post_reset: req_ready=%b init_done=%b, required 0/0", req_ready, init_done);
    end
`else
    if (req_ready !== 1'b1 || init_done !== 1'b1) begin
      errors++; $display("FAIL post_reset: req_ready=%b init_done=%b, required 1/1", req_ready, init_done);
    end
`endif
  endtask

`ifdef MEM_PORT_CTRL_INIT_EN
  task automatic test_init;
    int n = 1;
    while (!init_done && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n != 32) begin errors++; $display("FAIL init_len: init_done after %0d cycles, required 32", n); end
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 32; i++) begin send(1'b0, 5'(i), 8'h0); recv(8'h00, 0); end
  endtask
`endif

  task automatic test_write_read;
    send(1'b1, 5'd3, 8'hA5); ref_mem[3] = 8'hA5;
    checks++;
    if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 5'd3 || mem_data !== 8'hA5 || req_ready !== 1'b0) begin
      errors++; $display("FAIL write_cycle: wr=%b rd=%b addr=%h data=%h rdy=%b, required 1/0/03/a5/0",
                          mem_wr, mem_rd, mem_addr, mem_data, req_ready);
    end
    @(negedge clk);
    checks++;
    if (mem_wr !== 1'b0 || req_ready !== 1'b1 || mem[3] !== 8'hA5) begin
      errors++; $display("FAIL write_done: wr=%b rdy=%b mem[3]=%h, required 0/1/a5", mem_wr, req_ready, mem[3]);
    end
    send(1'b0, 5'd3, 8'h00);
    checks++;
    if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL read_cycle: rd=%b wr=%b rdy=%b vld=%b, required 1/0/0/0", mem_rd, mem_wr, req_ready, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5 || mem_rd !== 1'b0) begin
      errors++; $display("FAIL read_rsp: vld=%b data=%h rd=%b, required 1/a5/0", rsp_valid, rsp_data, mem_rd);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL read_release: vld=%b rdy=%b, required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] d = 8'($urandom);
    send(1'b1, 5'd7, d); ref_mem[7] = d;
    rsp_ready = 0;
    send(1'b0, 5'd7, 8'h00);
    req_valid = 1; req_we = 1; req_addr = 5'd9; req_wdata = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== d || req_ready !== 1'b0) begin
        errors++; $display("FAIL backpressure: cyc=%0d vld=%b data=%h rdy=%b, required 1/%h/0", i, rsp_valid, rsp_data, req_ready, d);
      end
    end
    req_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_wr !== 1'b0) begin
      errors++; $display("FAIL bp_release: vld=%b rdy=%b wr=%b, required 0/1/0", rsp_valid, req_ready, mem_wr);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 200; i++) begin
      logic we = 1'($urandom);
      logic [4:0] a = 5'($urandom);
      logic [7:0] d = 8'($urandom);
      send(we, a, d);
      if (we) ref_mem[a] = d;
      else recv(ref_mem[a], $urandom_range(0, 2));
    end
  endtask

  task automatic test_wrap;
    send(1'b1, 5'd31, 8'h11); ref_mem[31] = 8'h11;
    send(1'b1, 5'd0, 8'h22); ref_mem[0] = 8'h22;
    send(1'b0, 5'd31, 8'h00); recv(8'h11, 0);
    send(1'b0, 5'd0, 8'h00); recv(8'h22, 0);
  endtask

  task automatic test_reset_mid_read;
    send(1'b0, 5'd5, 8'h00);
    rst_n = 0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: req_ready=%b, required 0", req_ready); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
      errors++; $display("FAIL rst_mid_read: vld=%b rd=%b wr=%b, required 0/0/0", rsp_valid, mem_rd, mem_wr);
    end
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_rsp: cyc=%0d rsp_valid=%b, required 0", i, rsp_valid); end
    end
`ifdef MEM_PORT_CTRL_INIT_EN
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
`endif
    send(1'b0, 5'd0, 8'h00); recv(ref_mem[0], 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
`ifdef MEM_PORT_CTRL_INIT_EN
      mem[i] = 8'hFF;
`else
      mem[i] = 8'($urandom);
`endif
      ref_mem[i] = mem[i];
    end
    test_reset;
`ifdef MEM_PORT_CTRL_INIT_EN
    test_init;
`endif
    mon_en = 1;
    test_write_read;
    test_backpressure;
    test_random;
    test_wrap;
    test_reset_mid_read;
    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
